// File: rtl/dsm_dac_v2.sv
// Single-bit delta-sigma DAC modulator, runtime 1st/2nd order, saturating integrators,
// optional LFSR dither, 1-deep valid/ready sample buffer and runtime oversampling ratio.
module dsm_dac_v2 #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = DATA_WIDTH + 4,
    parameter int unsigned OSR_WIDTH  = 8,
    parameter bit          DITHER_EN  = 1'b0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_order,
    input  logic [OSR_WIDTH-1:0]         i_osr,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic                         o_dac_bitstream,
    output logic                         o_overflow,
    output logic                         o_underrun,
    input  logic                         i_clr_status
);

    localparam int unsigned EXT_WIDTH = ACC_WIDTH + 2;
    typedef logic signed [EXT_WIDTH-1:0] ext_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    localparam ext_t FB      = ext_t'(longint'(1) << (DATA_WIDTH - 1));
    localparam ext_t ACC_MAX = ext_t'((longint'(1) << (ACC_WIDTH - 1)) - 1);
    localparam ext_t ACC_MIN = ext_t'(-(longint'(1) << (ACC_WIDTH - 1)));
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    acc_t                         int1_q, int1_d;
    acc_t                         int2_q, int2_d;
    logic signed [DATA_WIDTH-1:0] active_q, active_d;
    logic signed [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                         buf_vld_q, buf_vld_d;
    logic [OSR_WIDTH-1:0]         osr_cnt_q, osr_cnt_d;
    logic [15:0]                  lfsr_q, lfsr_d;
    logic                         order_q;
    logic                         overflow_q, overflow_d;
    logic                         underrun_q, underrun_d;

    logic                 q;
    logic [OSR_WIDTH-1:0] osr_max;
    logic                 boundary;
    logic                 accept;
    logic                 order_chg;
    ext_t                 fb;
    ext_t                 dither;
    ext_t                 sum1, sum2;
    logic                 clip1, clip2;
    logic                 ovf_set, unr_set;

    function automatic acc_t clamp(ext_t v);
        if (v > ACC_MAX) begin
            return ACC_MAX[ACC_WIDTH-1:0];
        end else if (v < ACC_MIN) begin
            return ACC_MIN[ACC_WIDTH-1:0];
        end
        return v[ACC_WIDTH-1:0];
    endfunction

    // An integrator value of zero counts as non-negative, so reset drives a 1.
    assign q         = order_q ? !int2_q[ACC_WIDTH-1] : !int1_q[ACC_WIDTH-1];
    assign osr_max   = (i_osr == '0) ? OSR_WIDTH'(1) : i_osr;
    assign boundary  = i_en && (osr_cnt_q == osr_max - OSR_WIDTH'(1));
    assign accept    = i_valid && !buf_vld_q;
    assign order_chg = (i_order != order_q);
    assign fb        = q ? FB : -FB;
    assign dither    = DITHER_EN ? (ext_t'(lfsr_q[2:0]) - ext_t'(4)) : '0;
    assign sum1      = ext_t'(int1_q) + ext_t'(active_q) - fb + dither;
    assign sum2      = ext_t'(int2_q) + ext_t'(int1_q) - fb;
    assign clip1     = (sum1 > ACC_MAX) || (sum1 < ACC_MIN);
    assign clip2     = (sum2 > ACC_MAX) || (sum2 < ACC_MIN);

    always_comb begin
        int1_d  = int1_q;
        int2_d  = int2_q;
        ovf_set = 1'b0;
        // An order switch restarts the loop from zero regardless of the tick.
        if (order_chg) begin
            int1_d = '0;
            int2_d = '0;
        end else if (i_en) begin
            int1_d  = clamp(sum1);
            int2_d  = order_q ? clamp(sum2) : '0;
            ovf_set = clip1 || (order_q && clip2);
        end
    end

    always_comb begin
        osr_cnt_d = osr_cnt_q;
        lfsr_d    = lfsr_q;
        if (i_en) begin
            osr_cnt_d = boundary ? '0 : osr_cnt_q + OSR_WIDTH'(1);
            lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_comb begin
        active_d  = active_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        unr_set   = 1'b0;
        if (boundary) begin
            if (buf_vld_q) begin
                active_d  = buf_q;
                buf_vld_d = 1'b0;
            end else begin
                unr_set = 1'b1;
            end
        end
        // Accept needs an empty buffer, unload needs a full one: never both.
        if (accept) begin
            buf_d     = i_data;
            buf_vld_d = 1'b1;
        end
    end

    always_comb begin
        overflow_d = ovf_set || (overflow_q && !i_clr_status);
        underrun_d = unr_set || (underrun_q && !i_clr_status);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            int1_q     <= '0;
            int2_q     <= '0;
            active_q   <= '0;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            osr_cnt_q  <= '0;
            lfsr_q     <= LFSR_SEED;
            order_q    <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            int1_q     <= int1_d;
            int2_q     <= int2_d;
            active_q   <= active_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            osr_cnt_q  <= osr_cnt_d;
            lfsr_q     <= lfsr_d;
            order_q    <= i_order;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_ready         = !buf_vld_q;
    assign o_dac_bitstream = q;
    assign o_overflow      = overflow_q;
    assign o_underrun      = underrun_q;

endmodule
